// File: rtl/regfile_dump_scanner_pkg.sv
// Shared definitions for the register-dump engine: FSM state encodings and default geometry.
// Optional checksum word is enabled by defining REGDUMP_CHECKSUM_EN.
package regfile_dump_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_CSUM = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = 5;
    localparam int DEF_DW   = 32;

endpackage

// File: rtl/regfile_dump_scanner.sv
// Sweeps the register file debug port and streams {index, value} words over valid/ready.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module regfile_dump_scanner
    import regfile_dump_scanner_pkg::*;
#(
    parameter int NREG   = DEF_NREG,
    parameter int ADDR_W = DEF_AW,
    parameter int DATA_W = DEF_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ra_debug,
    input  logic [DATA_W-1:0] ra_debug_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_tag
);

    localparam int              LAST_INT = NREG - 1;
    localparam logic [ADDR_W:0] LAST_IDX = LAST_INT[ADDR_W:0];

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W:0]   idx_r;
    logic [ADDR_W:0]   idx_inc_s;
    logic              last_idx_s;
    logic              hs_s;
    logic              abort_s;

    assign idx_inc_s  = idx_r + {{ADDR_W{1'b0}}, 1'b1};
    assign last_idx_s = (idx_r == LAST_IDX);
    assign hs_s       = out_valid & out_ready;
    assign abort_s    = abort & (state_r != ST_IDLE);

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_r;

    function automatic logic [DATA_W-1:0] csum_fold(input logic [DATA_W-1:0] acc,
                                                    input logic [DATA_W-1:0] word);
        return acc ^ word;
    endfunction
`else
    assign out_tag = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; abort beats every other event outside IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) state_next_s = ST_LOAD;
                else                 state_next_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (abort) state_next_s = ST_IDLE;
                else       state_next_s = ST_SEND;
            end
            ST_SEND: begin
                if (abort)            state_next_s = ST_IDLE;
                else if (!hs_s)       state_next_s = ST_SEND;
                else if (!last_idx_s) state_next_s = ST_LOAD;
`ifdef REGDUMP_CHECKSUM_EN
                else                  state_next_s = ST_CSUM;
`else
                else                  state_next_s = ST_FIN;
`endif
            end
            ST_CSUM: begin
`ifdef REGDUMP_CHECKSUM_EN
                if (abort)      state_next_s = ST_IDLE;
                else if (hs_s)  state_next_s = ST_FIN;
                else            state_next_s = ST_CSUM;
`else
                state_next_s = ST_IDLE;
`endif
            end
            ST_FIN:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Index counter, read address, output word and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r     <= '0;
            ra_debug  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            out_tag   <= 1'b0;
            csum_r    <= '0;
`endif
        end else if (abort_s) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        idx_r    <= '0;
                        ra_debug <= '0;
                        busy     <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                        csum_r   <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    out_data  <= ra_debug_data;
                    out_idx   <= idx_r[ADDR_W-1:0];
                    out_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
                    out_tag   <= 1'b0;
                    csum_r    <= csum_fold(csum_r, ra_debug_data);
`else
                    out_last  <= last_idx_s;
`endif
                end
                ST_SEND: begin
                    if (hs_s) begin
                        if (!last_idx_s) begin
                            idx_r     <= idx_inc_s;
                            ra_debug  <= idx_inc_s[ADDR_W-1:0];
                            out_valid <= 1'b0;
                        end else begin
`ifdef REGDUMP_CHECKSUM_EN
                            // Checksum word follows immediately; csum_r already folds every register
                            out_valid <= 1'b1;
                            out_tag   <= 1'b1;
                            out_idx   <= '0;
                            out_data  <= csum_r;
                            out_last  <= 1'b1;
`else
                            out_valid <= 1'b0;
                            done      <= 1'b1;
`endif
                        end
                    end
                end
                ST_CSUM: begin
                    if (hs_s) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                ST_FIN: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_scanner.sv
// Randomized self-checking bench: register-file model plus snapshot-based reference of each dump.
module tb_regfile_dump_scanner;

    localparam int NREG = 32;
`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
    localparam int NW      = NREG + 1;
`else
    localparam bit CSUM_ON = 1'b0;
    localparam int NW      = NREG;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, busy, done;
    logic [4:0]  ra_debug;
    logic [31:0] ra_debug_data;
    logic        out_valid, out_ready, out_last, out_tag;
    logic [4:0]  out_idx;
    logic [31:0] out_data;

    logic [31:0] rf [NREG];
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (we) rf[wa] <= wd;
    assign ra_debug_data = (ra_debug == 5'd0) ? 32'd0 : rf[ra_debug];

    regfile_dump_scanner dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .ra_debug(ra_debug), .ra_debug_data(ra_debug_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .out_last(out_last), .out_tag(out_tag)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else             n_pass++;
    endtask

    task automatic set_reg(input int a, input logic [31:0] v);
        @(negedge clk);
        we = 1'b1; wa = a[4:0]; wd = v;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ra"}, ra_debug, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_idx"}, out_idx, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_tag"}, out_tag, 0);
    endtask

    // One dump: expected words come from a snapshot of the register model taken at start.
    task automatic run_dump(input int ready_pct, input int hold_idx, input int abort_at,
                            input int rst_at, input int glitch_at, input int wr_idx,
                            input logic [31:0] wr_val);
        logic [31:0] snap [NREG];
        logic [31:0] x, e_data;
        int          e_idx, w, held, cyc;
        bit          e_last, e_tag, fin;
        x = 32'd0;
        for (int i = 0; i < NREG; i++) begin
            snap[i] = (i == 0) ? 32'd0 : rf[i];
            x ^= snap[i];
        end
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("valid_in_first_load", out_valid, 0);
        w = 0; held = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            we = 1'b0; abort = 1'b0; start = 1'b0; out_ready = 1'b0;
            if (cyc == 1) chk("first_valid_latency", out_valid, 1);
            if (w == NW) begin
                chk("done_pulse", done, 1);
                chk("valid_after_last", out_valid, 0);
                chk("busy_in_fin", busy, 1);
                @(negedge clk);
                chk("busy_back_idle", busy, 0);
                chk("done_one_cycle", done, 0);
                fin = 1'b1;
            end else if (out_valid) begin
                if (w < NREG) begin
                    e_idx = w; e_data = snap[w]; e_tag = 1'b0;
                    e_last = (w == NREG - 1) && !CSUM_ON;
                end else begin
                    e_idx = 0; e_data = x; e_tag = 1'b1; e_last = 1'b1;
                end
                chk("word_idx", out_idx, e_idx);
                chk("word_data", out_data, e_data);
                chk("word_last", out_last, e_last);
                chk("word_tag", out_tag, e_tag);
                chk("done_low_mid", done, 0);
                if (w == abort_at) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_valid", out_valid, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_done", done, 0);
                    @(negedge clk);
                    chk("abort_no_done", done, 0);
                    fin = 1'b1;
                end else if (w == rst_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk_zero_outputs("midreset");
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    chk("midreset_no_done", done, 0);
                    chk("midreset_idle", busy, 0);
                    fin = 1'b1;
                end else begin
                    if (w == glitch_at) start = 1'b1;
                    if (w == hold_idx && held < 5) begin
                        held++;
                        out_ready = 1'b0;
                    end else begin
                        out_ready = ($urandom_range(99) < ready_pct);
                    end
                    if (out_ready) w++;
                end
            end else begin
                chk("busy_in_load", busy, 1);
                if (w == wr_idx && ra_debug == wr_idx[4:0]) begin
                    we = 1'b1; wa = wr_idx[4:0]; wd = wr_val;
                end
            end
        end
        if (!fin) chk("dump_timeout", 0, 1);
        if (hold_idx >= 0 && abort_at < 0 && rst_at < 0) chk("hold_cycles", held, 5);
        we = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        we = 1'b0; wa = 5'd0; wd = 32'd0;
        for (int i = 0; i < NREG; i++) rf[i] = 32'd0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // Directed preload and full-speed dump
        set_reg(1, 32'h1111_1111);
        set_reg(31, 32'hDEAD_BEEF);
        run_dump(100, -1, -1, -1, -1, -1, 32'd0);

        // Backpressure on idx 3, then abort at idx 10 followed by a clean dump
        run_dump(100, 3, -1, -1, -1, -1, 32'd0);
        run_dump(100, -1, 10, -1, -1, -1, 32'd0);
        run_dump(100, -1, -1, -1, -1, -1, 32'd0);

        // Same-cycle write during LOAD of idx 5 must not be seen; next dump sees it
        run_dump(100, -1, -1, -1, -1, 5, 32'hA5A5_A5A5);
        chk("r5_written", rf[5], 32'hA5A5_A5A5);
        run_dump(100, -1, -1, -1, 2, -1, 32'd0);

        // Reset mid-dump at idx 7, then a normal dump
        run_dump(100, -1, -1, 7, 3, -1, 32'd0);
        run_dump(100, -1, -1, -1, -1, -1, 32'd0);

        // abort and start together in IDLE: no dump
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("idle_abort_start_busy", busy, 0);
        @(negedge clk);
        chk("idle_abort_start_valid", out_valid, 0);

        // Checksum pattern
        for (int i = 1; i < NREG; i++) set_reg(i, 32'd0);
        set_reg(1, 32'hF0F0_F0F0);
        set_reg(2, 32'h0F0F_0F0F);
        run_dump(100, -1, -1, -1, -1, -1, 32'd0);

        // Randomized contents, backpressure and stray start pulses
        for (int t = 0; t < 4; t++) begin
            for (int i = 1; i < NREG; i++) set_reg(i, $urandom);
            run_dump(50, $urandom_range(NREG - 1), -1, -1, $urandom_range(NREG - 1), -1, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
